// File: rtl/regbank_pkg.sv
// Shared sizes and types for the register bank and its scoreboard.
package regbank_pkg;

    localparam int NREG = 32;
    localparam int IDXW = 5;
    localparam int DW   = 20;

    typedef logic [IDXW-1:0] reg_idx_t;
    typedef logic [DW-1:0]   reg_word_t;

endpackage : regbank_pkg

// File: rtl/wb_onehot_dec.sv
// 5-bit index to 32-bit one-hot strobe; all zero when not enabled.
module wb_onehot_dec
    import regbank_pkg::*;
(
    input  logic             en_i,
    input  reg_idx_t         idx_i,
    output logic [NREG-1:0]  onehot_o
);

    // Single set bit at idx_i while enabled, otherwise no strobe.
    always_comb begin
        onehot_o = {NREG{1'b0}};
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end else begin
            onehot_o = {NREG{1'b0}};
        end
    end

endmodule : wb_onehot_dec

// File: rtl/regbank_scoreboard.sv
// 32 x DW register bank with a per-register busy scoreboard and an
// incrementally maintained pending counter. regs_out feeds the read mux.
module regbank_scoreboard
    import regbank_pkg::*;
#(
    parameter int NREG_P  = NREG,
    parameter int DW_P    = DW,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [4:0]                    wr_addr,
    input  logic [DW_P-1:0]               wr_data,
    input  logic                          claim_en,
    input  logic [4:0]                    claim_addr,
    output logic                          claim_stall,
    output logic [NREG_P-1:0][DW_P-1:0]   regs_out,
    output logic [NREG_P-1:0]             busy_vec,
    output logic [5:0]                    pending_cnt,
    output logic                          all_idle
);

    // r0 never takes writes or claims when it is hardwired to zero.
    localparam logic [NREG_P-1:0] R0_MASK =
        ZERO_R0 ? {{(NREG_P-1){1'b1}}, 1'b0} : {NREG_P{1'b1}};

    logic [NREG_P-1:0][DW_P-1:0] regs_q, regs_d;
    logic [NREG_P-1:0]           busy_q, busy_d;
    logic [5:0]                  cnt_q, cnt_d;
    logic                        idle_q;

    logic [NREG_P-1:0] wr_oh_s, claim_oh_s;
    logic [NREG_P-1:0] wr_eff_s, claim_eff_s;
    logic              same_addr_wr_s;
    logic              claim_ok_s;
    logic              inc_s, dec_s;

    wb_onehot_dec u_wr_dec (
        .en_i     (wr_en),
        .idx_i    (wr_addr),
        .onehot_o (wr_oh_s)
    );

    wb_onehot_dec u_claim_dec (
        .en_i     (claim_ok_s),
        .idx_i    (claim_addr),
        .onehot_o (claim_oh_s)
    );

    // Stall decision: a same-cycle write to the target releases it first.
    always_comb begin
        same_addr_wr_s = wr_en & (wr_addr == claim_addr);
        if (rst) begin
            claim_stall = 1'b0;
        end else begin
            claim_stall = claim_en & busy_q[claim_addr] & ~same_addr_wr_s;
        end
        claim_ok_s  = claim_en & ~claim_stall;
        wr_eff_s    = wr_oh_s & R0_MASK;
        claim_eff_s = claim_oh_s & R0_MASK;
    end

    // Next state for data, busy bits and the pending counter.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NREG_P; i++) begin
            if (wr_eff_s[i]) begin
                regs_d[i] = wr_data;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
        // A claim beats a same-register write: bit ends set.
        busy_d = ((busy_q & ~wr_eff_s) | claim_eff_s) & R0_MASK;
        // Count only real bit transitions; strobes are one-hot so each is 0/1.
        inc_s  = |(claim_eff_s & ~busy_q);
        dec_s  = |(wr_eff_s & busy_q & ~claim_eff_s);
        cnt_d  = cnt_q + {5'd0, inc_s} - {5'd0, dec_s};
    end

    // State registers; reset wins over any concurrent write or claim.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
            busy_q <= {NREG_P{1'b0}};
            cnt_q  <= 6'd0;
            idle_q <= 1'b1;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            idle_q <= (cnt_d == 6'd0);
        end
    end

    // Read-mux feed: stored values, optionally overlaid with write-back data.
    always_comb begin
        regs_out = regs_q;
        for (int i = 0; i < NREG_P; i++) begin
            if (BYPASS && wr_eff_s[i]) begin
                regs_out[i] = wr_data;
            end else begin
                regs_out[i] = regs_q[i];
            end
        end
    end

    assign busy_vec    = busy_q;
    assign pending_cnt = cnt_q;
    assign all_idle    = idle_q;

endmodule : regbank_scoreboard

// File: doc/regbank_scoreboard.md
Name: regbank_scoreboard

Overview:
- 32-entry x 20-bit register bank with a per-register busy scoreboard.
- Sits directly upstream of the 32-channel x 20-bit read multiplexer and drives that multiplexer's packed data input (regs_out).
- Write-back port writes one register per cycle and clears its busy bit.
- Claim port marks a destination register busy at issue and stalls when the target is already pending.

Parameters:
- NREG, 32, number of registers; fixed at 32 to match the 5-bit selector.
- DW, 20, register data width.
- ZERO_R0, 1, when 1 register 0 reads 0 forever and ignores writes and claims.
- BYPASS, 1, when 1 regs_out shows the write-back data in the same cycle as the write.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write-back valid
- wr_addr  in  5  write-back register index
- wr_data  in  DW  write-back data
- claim_en  in  1  issue requests destination reservation
- claim_addr  in  5  destination register to mark busy
- claim_stall  out  1  combinational; claim refused this cycle
- regs_out  out  [31:0][DW-1:0]  packed register contents, feeds the read mux
- busy_vec  out  32  registered busy bits
- pending_cnt  out  6  registered count of busy registers, 0..32
- all_idle  out  1  registered; pending_cnt == 0

Behaviour:
- Reset (rst high at a clk edge):
  - all registers, busy_vec and pending_cnt go to 0; all_idle goes to 1.
  - rst overrides any simultaneous write or claim.
  - claim_stall is 0 while rst is high.
- Write:
  - When wr_en=1 at an edge, regs[wr_addr] <= wr_data and busy[wr_addr] <= 0.
  - Latency is 1 cycle to the registered state.
  - Writing a non-busy register is legal: data updates, busy stays 0, count unchanged.
- Bypass:
  - With BYPASS=1, regs_out[wr_addr] = wr_data combinationally while wr_en=1; all other channels show stored values.
  - With BYPASS=0, regs_out is purely registered.
- Claim:
  - claim_stall = claim_en & busy[claim_addr] & ~(wr_en & wr_addr==claim_addr).
  - A write to the same register in the same cycle releases it, so the claim does not stall.
  - A claim is accepted when claim_en=1 and claim_stall=0; then busy[claim_addr] <= 1 at the edge.
  - A stalled claim changes no state; the issuer holds and retries.
- Same-address write and claim in one cycle: data is written and busy ends at 1 (the new claim wins).
- ZERO_R0=1:
  - writes to r0 are dropped and regs_out[0] is always 0, including under bypass.
  - claims to r0 are accepted silently with claim_stall=0, and busy[0] stays 0.
- pending_cnt is incremental, never recomputed by popcount:
  - +1 when a claim sets a previously clear bit.
  - -1 when a write clears a previously set bit.
  - Both in one cycle on different registers: net 0.
  - Same register in one cycle: bit stays 1, net 0.
  - It cannot exceed 32 or go below 0.
- all_idle is registered from the next-state count, so it updates in the same cycle as pending_cnt.
- Out-of-range indices are impossible (5-bit index, 32 entries).

Decomposition:
- Shared package regbank_pkg holds:
  - localparams NREG=32, IDXW=5, DW=20;
  - typedef reg_idx_t (logic [4:0]);
  - typedef reg_word_t (logic [19:0]).
- One sub-module, wb_onehot_dec: 5-bit index plus enable in, 32-bit one-hot out, all zero when disabled.
  - Instantiated twice: once for the write strobe, once for the claim strobe.
- Register array, scoreboard and counter live in the top level.

Test Plan:
- Reset: rst=1 for 2 cycles -> regs_out all 0, busy_vec=0, pending_cnt=0, all_idle=1, claim_stall=0.
- Write, then bypass: wr_en=1, wr_addr=5, wr_data=20'hABCDE.
  - With BYPASS=1 -> regs_out[5]=20'hABCDE in the same cycle.
  - Next cycle with wr_en=0 -> value persists and the other channels stay 0.
- r0 protection: write 20'hFFFFF to r0 and claim r0 -> regs_out[0]=0, busy_vec[0]=0, pending_cnt=0.
- Claim and stall:
  - Claim r7 -> busy_vec=32'h80, pending_cnt=1.
  - Claim r7 again -> claim_stall=1 and state unchanged.
  - Write r7 with data 20'h00012 -> busy_vec=0, pending_cnt=0, all_idle=1.
- Same-cycle interactions:
  - With r9 busy, claim r9 and write r9 (data 20'h00033) together -> claim_stall=0, regs[9]=20'h00033, busy_vec[9]=1, pending_cnt unchanged at 1.
  - Claim r3 while writing busy r9 -> pending_cnt stays 1, busy_vec=32'h8.
- Saturation and reset mid-run:
  - Claim r1..r31 over 31 cycles -> pending_cnt=31, busy_vec=32'hFFFFFFFE.
  - Assert rst mid-sequence with wr_en=1 -> everything returns to 0 and the write is discarded.
